// File: rtl/arcade_input_mapper.sv
// Player-input front end for arcade cores: PS/2 key decode merged with MiSTer joysticks,
// screen-rotation remap, opposing-direction cleanup, coin stretching and autofire.
module arcade_input_mapper #(
    parameter int PLAYERS      = 2,
    parameter int BUTTONS      = 4,
    parameter int COIN_PULSE   = 240000,
    parameter int AUTOFIRE_DIV = 600000,
    parameter int SOCD_CLEAN   = 1
) (
    input  logic                         clk_sys,
    input  logic                         reset,
    input  logic [10:0]                  ps2_key,
    input  logic [16*PLAYERS-1:0]        joystick,
    input  logic [1:0]                   rotate,
    input  logic [PLAYERS-1:0]           autofire_en,
    output logic [4*PLAYERS-1:0]         dir,
    output logic [BUTTONS*PLAYERS-1:0]   btn,
    output logic [PLAYERS-1:0]           start,
    output logic [PLAYERS-1:0]           coin,
    output logic                         service
);

    localparam int AF_W   = $clog2(AUTOFIRE_DIV);
    localparam int COIN_W = (COIN_PULSE > 0) ? $clog2(COIN_PULSE + 1) : 1;
    localparam logic [AF_W-1:0]   AF_LAST   = AF_W'(AUTOFIRE_DIV - 1);
    localparam logic [COIN_W-1:0] COIN_LOAD = COIN_W'(COIN_PULSE);

    logic       old_toggle;
    logic       ps2_event;
    logic       pressed;
    logic       ext;
    logic [7:0] code;

    logic [3:0] key_dir   [2];
    logic [3:0] key_btn   [2];
    logic [1:0] key_start [2];
    logic [1:0] key_coin;
    logic       key_service;

    logic [4*PLAYERS-1:0]       dir_next;
    logic [BUTTONS*PLAYERS-1:0] btn_next;
    logic [PLAYERS-1:0]         raw_start;
    logic [PLAYERS-1:0]         raw_coin;

    assign ps2_event = (old_toggle != ps2_key[10]);
    assign pressed   = ps2_key[9];
    assign ext       = ps2_key[8];
    assign code      = ps2_key[7:0];

    // Each start has two alternative keys, kept separately so releasing one does not drop the other.
    always_ff @(posedge clk_sys) begin
        old_toggle <= ps2_key[10];
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                key_dir[i]   <= '0;
                key_btn[i]   <= '0;
                key_start[i] <= '0;
            end
            key_coin    <= '0;
            key_service <= 1'b0;
        end else if (ps2_event) begin
            case (code)
                8'h75: key_dir[0][3] <= pressed;
                8'h72: key_dir[0][2] <= pressed;
                8'h6B: key_dir[0][1] <= pressed;
                8'h74: key_dir[0][0] <= pressed;
                8'h14: key_btn[0][0] <= pressed;
                8'h11: key_btn[0][1] <= pressed;
                default: begin
                    if (!ext) begin
                        case (code)
                            8'h29: key_btn[0][2]   <= pressed;
                            8'h12: key_btn[0][3]   <= pressed;
                            8'h16: key_start[0][0] <= pressed;
                            8'h05: key_start[0][1] <= pressed;
                            8'h2E: key_coin[0]     <= pressed;
                            8'h2D: key_dir[1][3]   <= pressed;
                            8'h2B: key_dir[1][2]   <= pressed;
                            8'h23: key_dir[1][1]   <= pressed;
                            8'h34: key_dir[1][0]   <= pressed;
                            8'h1C: key_btn[1][0]   <= pressed;
                            8'h1B: key_btn[1][1]   <= pressed;
                            8'h15: key_btn[1][2]   <= pressed;
                            8'h1D: key_btn[1][3]   <= pressed;
                            8'h1E: key_start[1][0] <= pressed;
                            8'h06: key_start[1][1] <= pressed;
                            8'h36: key_coin[1]     <= pressed;
                            8'h2C: key_service     <= pressed;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic [15:0]        joy;
        logic [3:0]         k_dir;
        logic [BUTTONS-1:0] k_btn;
        logic               k_start;
        logic               k_coin;
        logic [3:0]         raw_dir;
        logic [BUTTONS-1:0] raw_btn;
        logic [3:0]         rot_dir;
        logic [3:0]         clean_dir;
        logic [BUTTONS-1:0] btn_p;
        logic               unused_bits;

        assign joy         = joystick[16*p +: 16];
        assign unused_bits = ^joy[15:6+BUTTONS];

        if (p < 2) begin : g_keys
            assign k_dir   = key_dir[p];
            assign k_btn   = key_btn[p][BUTTONS-1:0];
            assign k_start = |key_start[p];
            assign k_coin  = key_coin[p];
        end else begin : g_no_keys
            assign k_dir   = '0;
            assign k_btn   = '0;
            assign k_start = 1'b0;
            assign k_coin  = 1'b0;
        end

        assign raw_dir      = k_dir | joy[3:0];
        assign raw_btn      = k_btn | joy[4 +: BUTTONS];
        assign raw_start[p] = k_start | joy[4+BUTTONS];
        assign raw_coin[p]  = k_coin | joy[5+BUTTONS];

        // Nibble layout is {up, down, left, right}; cleanup runs on the rotated directions.
        always_comb begin
            case (rotate)
                2'd1:    rot_dir = {raw_dir[1], raw_dir[0], raw_dir[2], raw_dir[3]};
                2'd2:    rot_dir = {raw_dir[2], raw_dir[3], raw_dir[0], raw_dir[1]};
                2'd3:    rot_dir = {raw_dir[0], raw_dir[1], raw_dir[3], raw_dir[2]};
                default: rot_dir = raw_dir;
            endcase
            clean_dir = rot_dir;
            if (SOCD_CLEAN != 0) begin
                if (rot_dir[3] && rot_dir[2]) clean_dir[3:2] = 2'b00;
                if (rot_dir[1] && rot_dir[0]) clean_dir[1:0] = 2'b00;
            end
        end

        assign dir_next[4*p +: 4] = clean_dir;

        logic [AF_W-1:0] af_cnt;
        logic [AF_W-1:0] af_cnt_next;
        logic            af_phase;
        logic            af_phase_next;
        logic            af_prev;

        // A fresh press restarts the burst in the firing phase so the first shot is immediate.
        always_comb begin
            af_cnt_next   = af_cnt;
            af_phase_next = af_phase;
            if (!raw_btn[0] || !autofire_en[p] || !af_prev) begin
                af_cnt_next   = '0;
                af_phase_next = 1'b1;
            end else if (af_cnt == AF_LAST) begin
                af_cnt_next   = '0;
                af_phase_next = ~af_phase;
            end else begin
                af_cnt_next   = af_cnt + 1'b1;
            end
        end

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                af_cnt   <= '0;
                af_phase <= 1'b1;
                af_prev  <= 1'b0;
            end else begin
                af_cnt   <= af_cnt_next;
                af_phase <= af_phase_next;
                af_prev  <= raw_btn[0];
            end
        end

        always_comb begin
            btn_p    = raw_btn;
            btn_p[0] = autofire_en[p] ? (raw_btn[0] & af_phase_next) : raw_btn[0];
        end

        assign btn_next[BUTTONS*p +: BUTTONS] = btn_p;

        if (COIN_PULSE == 0) begin : g_coin_pass
            logic coin_q;
            always_ff @(posedge clk_sys) begin
                if (reset) coin_q <= 1'b0;
                else       coin_q <= raw_coin[p];
            end
            assign coin[p] = coin_q;
        end else begin : g_coin_pulse
            logic [COIN_W-1:0] coin_cnt;
            logic              coin_prev;
            // Only an edge seen while idle starts a pulse; holding or re-pressing never extends it.
            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    coin_cnt  <= '0;
                    coin_prev <= 1'b0;
                end else begin
                    coin_prev <= raw_coin[p];
                    if (coin_cnt == '0) begin
                        if (raw_coin[p] && !coin_prev) coin_cnt <= COIN_LOAD;
                    end else begin
                        coin_cnt <= coin_cnt - 1'b1;
                    end
                end
            end
            assign coin[p] = (coin_cnt != '0);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dir     <= '0;
            btn     <= '0;
            start   <= '0;
            service <= 1'b0;
        end else begin
            dir     <= dir_next;
            btn     <= btn_next;
            start   <= raw_start;
            service <= key_service;
        end
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Self-checking bench for arcade_input_mapper: two instances (cleanup+stretched coin, and
// no cleanup+pass-through coin) driven in lockstep, expectations queued and compared per edge.
module tb_arcade_input_mapper;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [31:0] joystick;
    logic [1:0]  rotate;
    logic [1:0]  autofire_en;

    logic [7:0] dir_a, btn_a, dir_b, btn_b;
    logic [1:0] start_a, coin_a, start_b, coin_b;
    logic       service_a, service_b;

    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper #(
        .PLAYERS(2), .BUTTONS(4), .COIN_PULSE(8), .AUTOFIRE_DIV(4), .SOCD_CLEAN(1)
    ) dut_a (
        .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joystick(joystick),
        .rotate(rotate), .autofire_en(autofire_en), .dir(dir_a), .btn(btn_a),
        .start(start_a), .coin(coin_a), .service(service_a)
    );

    arcade_input_mapper #(
        .PLAYERS(2), .BUTTONS(4), .COIN_PULSE(0), .AUTOFIRE_DIV(4), .SOCD_CLEAN(0)
    ) dut_b (
        .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joystick(joystick),
        .rotate(rotate), .autofire_en(autofire_en), .dir(dir_b), .btn(btn_b),
        .start(start_b), .coin(coin_b), .service(service_b)
    );

    typedef struct {
        logic [7:0] dir;
        logic [7:0] btn;
        logic [1:0] start;
        logic [1:0] coin;
        logic       service;
        logic [7:0] dir_b;
        logic [1:0] coin_b;
        string      name;
    } exp_t;

    typedef struct {
        logic [31:0] joy;
        logic [1:0]  rot;
        logic [7:0]  dir;
        logic [7:0]  dir_b;
        logic [7:0]  btn;
        logic [1:0]  start;
        string       name;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    exp_t cur;

    int errors = 0;
    int checks = 0;

    logic        nxt_reset;
    logic [10:0] nxt_ps2;
    logic [31:0] nxt_joy;
    logic [1:0]  nxt_rot;
    logic [1:0]  nxt_af;

    task automatic addVec(input logic [31:0] joy, input logic [1:0] rot, input logic [7:0] d,
                          input logic [7:0] d_b, input logic [7:0] b, input logic [1:0] s,
                          input string nm);
        vec_t v;
        v.joy = joy; v.rot = rot; v.dir = d; v.dir_b = d_b; v.btn = b; v.start = s; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic sendKey(input logic pr, input logic ex, input logic [7:0] cd);
        nxt_ps2 = {~nxt_ps2[10], pr, ex, cd};
    endtask

    task automatic clearExp();
        cur.dir = '0; cur.btn = '0; cur.start = '0; cur.coin = '0;
        cur.service = 1'b0; cur.dir_b = '0; cur.coin_b = '0;
    endtask

    task automatic applyStimulus();
        @(negedge clk_sys);
        reset       = nxt_reset;
        ps2_key     = nxt_ps2;
        joystick    = nxt_joy;
        rotate      = nxt_rot;
        autofire_en = nxt_af;
        exp_q.push_back(cur);
    endtask

    task automatic checkOutput();
        exp_t e;
        @(posedge clk_sys);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue, required one pending expectation");
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if ({dir_a, btn_a, start_a, coin_a, service_a} !== {e.dir, e.btn, e.start, e.coin, e.service}) begin
            errors++;
            $display("[TB] FAIL %s A: got dir=%h btn=%h start=%b coin=%b service=%b, required dir=%h btn=%h start=%b coin=%b service=%b",
                     e.name, dir_a, btn_a, start_a, coin_a, service_a, e.dir, e.btn, e.start, e.coin, e.service);
        end
        checks++;
        if ({dir_b, btn_b, start_b, coin_b, service_b} !== {e.dir_b, e.btn, e.start, e.coin_b, e.service}) begin
            errors++;
            $display("[TB] FAIL %s B: got dir=%h btn=%h start=%b coin=%b service=%b, required dir=%h btn=%h start=%b coin=%b service=%b",
                     e.name, dir_b, btn_b, start_b, coin_b, service_b, e.dir_b, e.btn, e.start, e.coin_b, e.service);
        end
    endtask

    task automatic step(input string nm);
        cur.name = nm;
        applyStimulus();
        checkOutput();
    endtask

    initial begin
        reset = 1'b1; ps2_key = '0; joystick = '0; rotate = '0; autofire_en = '0;
        nxt_reset = 1'b1; nxt_ps2 = '0; nxt_joy = '0; nxt_rot = '0; nxt_af = '0;
        clearExp();

        addVec(32'h0000_0008, 2'd0, 8'h08, 8'h08, 8'h00, 2'b00, "up_rot0");
        addVec(32'h0000_0008, 2'd1, 8'h01, 8'h01, 8'h00, 2'b00, "up_rot1");
        addVec(32'h0000_0008, 2'd2, 8'h04, 8'h04, 8'h00, 2'b00, "up_rot2");
        addVec(32'h0000_0008, 2'd3, 8'h02, 8'h02, 8'h00, 2'b00, "up_rot3");
        addVec(32'h0000_000C, 2'd0, 8'h00, 8'h0C, 8'h00, 2'b00, "socd_updown");
        addVec(32'h0000_0003, 2'd0, 8'h00, 8'h03, 8'h00, 2'b00, "socd_leftright");
        addVec(32'h0000_0001, 2'd1, 8'h04, 8'h04, 8'h00, 2'b00, "right_rot1");
        addVec(32'h0000_0002, 2'd3, 8'h04, 8'h04, 8'h00, 2'b00, "left_rot3");
        addVec(32'h000A_0000, 2'd2, 8'h50, 8'h50, 8'h00, 2'b00, "p2_upleft_rot2");
        addVec(32'h0100_00F0, 2'd0, 8'h00, 8'h00, 8'h0F, 2'b10, "p2_start_p1_fire");
        addVec(32'h0050_0100, 2'd0, 8'h00, 8'h00, 8'h50, 2'b01, "p1_start_p2_fire");
        addVec(32'h0000_000E, 2'd1, 8'h08, 8'h0B, 8'h00, 2'b00, "socd_after_rot1");
        addVec(32'h0000_0000, 2'd0, 8'h00, 8'h00, 8'h00, 2'b00, "idle");

        // Reset state, and an event toggled while reset is high must not leak out.
        step("reset0");
        step("reset1");
        sendKey(1'b1, 1'b0, 8'h75);
        step("reset_event");
        nxt_reset = 1'b0;
        step("post_reset0");
        step("post_reset1");
        step("post_reset2");

        foreach (vecs[i]) begin
            nxt_joy = vecs[i].joy;
            nxt_rot = vecs[i].rot;
            clearExp();
            cur.dir = vecs[i].dir; cur.dir_b = vecs[i].dir_b;
            cur.btn = vecs[i].btn; cur.start = vecs[i].start;
            step(vecs[i].name);
        end

        // PS/2 decode: two-edge latency, extended bit ignored or required per key.
        clearExp();
        sendKey(1'b1, 1'b1, 8'h75); step("p1_up_press_e1");
        cur.dir = 8'h08; cur.dir_b = 8'h08; step("p1_up_press_e2");
        sendKey(1'b0, 1'b1, 8'h75); step("p1_up_release_e1");
        cur.dir = 8'h00; cur.dir_b = 8'h00; step("p1_up_release_e2");
        sendKey(1'b1, 1'b1, 8'h2D); step("p2_up_ext_e1");
        step("p2_up_ext_e2");
        sendKey(1'b1, 1'b0, 8'h2D); step("p2_up_press_e1");
        cur.dir = 8'h80; cur.dir_b = 8'h80; step("p2_up_press_e2");
        sendKey(1'b1, 1'b0, 8'h2C); step("service_e1");
        cur.service = 1'b1; step("service_e2");
        sendKey(1'b1, 1'b0, 8'h05); step("f1_start_e1");
        cur.start = 2'b01; step("f1_start_e2");
        sendKey(1'b1, 1'b1, 8'h14); step("ctrl_ext_e1");
        cur.btn = 8'h01; step("ctrl_ext_e2");

        nxt_reset = 1'b1;
        clearExp();
        step("mid_reset");
        nxt_reset = 1'b0;
        step("held_key_hidden0");
        step("held_key_hidden1");

        // Coin key held for two cycles stretches to exactly eight.
        sendKey(1'b1, 1'b0, 8'h2E);
        step("coin_key_e0");
        for (int i = 1; i <= 10; i++) begin
            if (i == 2) sendKey(1'b0, 1'b0, 8'h2E);
            cur.coin   = (i <= 8) ? 2'b01 : 2'b00;
            cur.coin_b = (i == 1 || i == 2) ? 2'b01 : 2'b00;
            step($sformatf("coin_key_%0d", i));
        end

        for (int i = 0; i < 12; i++) begin
            nxt_joy    = (i == 0 || i == 3) ? 32'h0000_0200 : 32'h0;
            cur.coin   = (i < 8) ? 2'b01 : 2'b00;
            cur.coin_b = (i == 0 || i == 3) ? 2'b01 : 2'b00;
            step($sformatf("coin_retrigger_%0d", i));
        end

        for (int i = 0; i <= 20; i++) begin
            nxt_joy    = (i < 20) ? 32'h0000_0200 : 32'h0;
            cur.coin   = (i < 8) ? 2'b01 : 2'b00;
            cur.coin_b = (i < 20) ? 2'b01 : 2'b00;
            step($sformatf("coin_hold_%0d", i));
        end

        // Autofire with a half-period of four cycles, then release and a mid-burst disable.
        clearExp();
        nxt_af = 2'b01;
        for (int i = 0; i < 20; i++) begin
            nxt_joy = 32'h0000_0010;
            cur.btn = (((i / 4) % 2) == 0) ? 8'h01 : 8'h00;
            step($sformatf("autofire_%0d", i));
        end
        nxt_joy = 32'h0;
        cur.btn = 8'h00;
        step("autofire_release");

        for (int i = 0; i < 8; i++) begin
            nxt_joy = 32'h0000_0010;
            nxt_af  = (i < 6) ? 2'b01 : 2'b00;
            cur.btn = (i >= 6 || ((i / 4) % 2) == 0) ? 8'h01 : 8'h00;
            step($sformatf("autofire_disable_%0d", i));
        end
        nxt_joy = 32'h0;
        nxt_af  = 2'b00;
        cur.btn = 8'h00;
        step("autofire_disable_release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
